// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between execute and the data memory port: size/sign decode,
// lane alignment, request/valid handshake with timeout, and load extension.
module lsu_mem_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_mask,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(BYTES);
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state;
  logic [1:0]        sz_q;
  logic              uns_q;
  logic              we_q;
  logic [OFF_W-1:0]  off_q;
  logic [CNT_W-1:0]  cnt;

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);

  logic              a_illegal;
  logic              a_misal;
  logic [BYTES-1:0]  a_mask;
  logic [DATA_W-1:0] a_wdata;

  always_comb begin
    int unsigned nb;
    int unsigned offi;
    nb        = 32'd1 << req_funct3[1:0];
    offi      = 32'(req_addr[OFF_W-1:0]);
    a_illegal = (req_funct3 == 3'b111) ||
                ((DATA_W == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    a_misal   = (offi & (nb - 1)) != 0;
    a_mask    = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      a_mask[i] = (i >= offi) && (i < offi + nb);
    end
    a_wdata   = req_wdata << (8 * offi);
  end

  // Shift the addressed lanes down, then fill above the access size with the
  // sign of its top byte (or zeros for the unsigned variants).
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    int unsigned       nb;
    logic [DATA_W-1:0] shifted;
    logic [7:0]        lane;
    logic              sign;
    nb      = 32'd1 << sz_q;
    shifted = mem_rdata >> (8 * 32'(off_q));
    sign    = 1'b0;
    lane    = '0;
    ld_ext  = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane = shifted[8*i +: 8];
      if (i + 1 == nb) sign = lane[7] & ~uns_q;
    end
    for (int unsigned i = 0; i < BYTES; i++) begin
      ld_ext[8*i +: 8] = (i < nb) ? shifted[8*i +: 8] : {8{sign}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sz_q      <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      off_q     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_mask  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (a_illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b10;
              rsp_rdata <= '0;
            end else if (a_misal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b01;
              rsp_rdata <= '0;
            end else begin
              state     <= BUSY;
              sz_q      <= req_funct3[1:0];
              uns_q     <= req_funct3[2];
              we_q      <= req_we;
              off_q     <= req_addr[OFF_W-1:0];
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_mask  <= a_mask;
              mem_wdata <= a_wdata;
            end
          end
        end
        BUSY: begin
          // A response in the last counted cycle wins over the timeout.
          if (mem_valid || ((TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST)))) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= mem_valid ? 2'b00 : 2'b11;
            rsp_rdata <= (mem_valid && !we_q) ? ld_ext : '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_mask  <= '0;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= '0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: 32-bit (TIMEOUT=4) and 64-bit instances, vector
// tables plus hand sequences for timeout and reset-during-transaction.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        a_req_valid, a_req_ready, a_req_we, a_stall, a_rsp_valid;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_rsp_err;
  logic        a_mem_req, a_mem_we, a_mem_valid;
  logic [3:0]  a_mem_mask;

  logic        b_req_valid, b_req_ready, b_req_we, b_stall, b_rsp_valid;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_mem_addr;
  logic [63:0] b_req_wdata, b_rsp_rdata, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_rsp_err;
  logic        b_mem_req, b_mem_we, b_mem_valid;
  logic [7:0]  b_mem_mask;

  lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .stall(a_stall), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_mask(a_mem_mask),
    .mem_wdata(a_mem_wdata), .mem_valid(a_mem_valid), .mem_rdata(a_mem_rdata)
  );

  lsu_mem_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .stall(b_stall), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_mask(b_mem_mask),
    .mem_wdata(b_mem_wdata), .mem_valid(b_mem_valid), .mem_rdata(b_mem_rdata)
  );

  logic        use64;
  logic        s_req_ready, s_stall, s_rsp_valid, s_mem_req, s_mem_we;
  logic [1:0]  s_rsp_err;
  logic [31:0] s_mem_addr;
  logic [7:0]  s_mem_mask;
  logic [63:0] s_rsp_rdata, s_mem_wdata;

  always_comb begin
    s_req_ready = use64 ? b_req_ready : a_req_ready;
    s_stall     = use64 ? b_stall     : a_stall;
    s_rsp_valid = use64 ? b_rsp_valid : a_rsp_valid;
    s_rsp_err   = use64 ? b_rsp_err   : a_rsp_err;
    s_rsp_rdata = use64 ? b_rsp_rdata : {32'h0, a_rsp_rdata};
    s_mem_req   = use64 ? b_mem_req   : a_mem_req;
    s_mem_we    = use64 ? b_mem_we    : a_mem_we;
    s_mem_addr  = use64 ? b_mem_addr  : a_mem_addr;
    s_mem_mask  = use64 ? b_mem_mask  : {4'h0, a_mem_mask};
    s_mem_wdata = use64 ? b_mem_wdata : {32'h0, a_mem_wdata};
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [31:0] e_addr;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata;
    logic [1:0]  e_err;
    logic [63:0] e_rdata;
    int          delay;
  } vec_t;

  typedef struct {
    logic [1:0]  err;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rdata,
                              input logic [31:0] e_addr, input logic [7:0] e_mask,
                              input logic [63:0] e_wdata, input logic [1:0] e_err,
                              input logic [63:0] e_rdata, input int delay);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.e_addr = e_addr; v.e_mask = e_mask; v.e_wdata = e_wdata;
    v.e_err = e_err; v.e_rdata = e_rdata; v.delay = delay;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    if (use64) begin
      b_req_valid = 1'b1; b_req_we = v.we; b_req_funct3 = v.f3;
      b_req_addr = v.addr; b_req_wdata = v.wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = v.we; a_req_funct3 = v.f3;
      a_req_addr = v.addr; a_req_wdata = v.wdata[31:0];
    end
  endtask

  task automatic idle_req();
    a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = 32'h5A5A_5A5A;
    b_req_valid = 1'b0; b_req_addr = 32'hFFFF_FFFF; b_req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    check({tag, "_rsp_valid"}, s_rsp_valid, 1'b1);
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_sb_underflow: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rsp_err"}, s_rsp_err, e.err);
      check({tag, "_rsp_rdata"}, s_rsp_rdata, e.rdata);
    end
  endtask

  // One transaction, starting in an idle cycle and ending in its RESP cycle.
  task automatic xact(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    check({tag, "_req_ready"}, s_req_ready, 1'b1);
    check({tag, "_no_rsp"}, s_rsp_valid, 1'b0);
    drive_req(v);
    e.err = v.e_err; e.rdata = v.e_rdata;
    sb.push_back(e);
    @(negedge clk);
    idle_req();
    if (v.e_err == 2'b00) begin
      check({tag, "_mem_req"}, s_mem_req, 1'b1);
      check({tag, "_stall"}, s_stall, 1'b1);
      check({tag, "_mem_we"}, s_mem_we, v.we);
      check({tag, "_mem_addr"}, s_mem_addr, v.e_addr);
      check({tag, "_mem_mask"}, s_mem_mask, v.e_mask);
      check({tag, "_mem_wdata"}, s_mem_wdata, v.e_wdata);
      for (int i = 0; i < v.delay; i++) begin
        @(negedge clk);
        check({tag, "_mem_req_hold"}, s_mem_req, 1'b1);
        check({tag, "_mem_mask_hold"}, s_mem_mask, v.e_mask);
      end
      if (use64) begin b_mem_valid = 1'b1; b_mem_rdata = v.rdata; end
      else begin a_mem_valid = 1'b1; a_mem_rdata = v.rdata[31:0]; end
      @(negedge clk);
      a_mem_valid = 1'b0; a_mem_rdata = '1;
      b_mem_valid = 1'b0; b_mem_rdata = '1;
      check({tag, "_mem_req_drop"}, s_mem_req, 1'b0);
    end else begin
      check({tag, "_err_no_mem_req"}, s_mem_req, 1'b0);
    end
    check_rsp(tag);
  endtask

  vec_t tab32[$];
  vec_t tab64[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vec_t v;
    use64 = 1'b0;
    idle_req();
    a_req_we = 1'b0; a_req_funct3 = 3'b000;
    b_req_we = 1'b0; b_req_funct3 = 3'b000;
    a_mem_valid = 1'b0; a_mem_rdata = '1;
    b_mem_valid = 1'b0; b_mem_rdata = '1;

    //            we  f3      addr          wdata                  rdata                  e_addr        mask   e_wdata                e_err  e_rdata                dly
    tab32.push_back(mk(1, 3'b010, 32'h104, 64'hDEADBEEF,          64'h0,                 32'h104, 8'h0F, 64'hDEADBEEF,          2'b00, 64'h0,                 0));
    tab32.push_back(mk(0, 3'b000, 32'h203, 64'h0,                 64'h80123456,          32'h200, 8'h08, 64'h0,                 2'b00, 64'hFFFFFF80,          1));
    tab32.push_back(mk(0, 3'b100, 32'h203, 64'h0,                 64'h80123456,          32'h200, 8'h08, 64'h0,                 2'b00, 64'h00000080,          3));
    tab32.push_back(mk(1, 3'b001, 32'h102, 64'h0000ABCD,          64'h0,                 32'h100, 8'h0C, 64'hABCD0000,          2'b00, 64'h0,                 0));
    tab32.push_back(mk(0, 3'b001, 32'h101, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b01, 64'h0,                 0));
    tab32.push_back(mk(0, 3'b101, 32'h102, 64'h0,                 64'h87654321,          32'h100, 8'h0C, 64'h0,                 2'b00, 64'h00008765,          2));
    tab32.push_back(mk(0, 3'b001, 32'h100, 64'h0,                 64'h12348001,          32'h100, 8'h03, 64'h0,                 2'b00, 64'hFFFF8001,          0));
    tab32.push_back(mk(0, 3'b010, 32'h10C, 64'h0,                 64'h80000001,          32'h10C, 8'h0F, 64'h0,                 2'b00, 64'h80000001,          1));
    tab32.push_back(mk(0, 3'b010, 32'h10E, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b01, 64'h0,                 0));
    tab32.push_back(mk(0, 3'b011, 32'h100, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b10, 64'h0,                 0));
    tab32.push_back(mk(0, 3'b111, 32'h101, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b10, 64'h0,                 0));
    tab32.push_back(mk(0, 3'b110, 32'h102, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b10, 64'h0,                 0));
    tab32.push_back(mk(1, 3'b000, 32'h201, 64'h000000A5,          64'h0,                 32'h200, 8'h02, 64'h0000A500,          2'b00, 64'h0,                 0));

    tab64.push_back(mk(1, 3'b011, 32'h108, 64'h1122334455667788,  64'h0,                 32'h108, 8'hFF, 64'h1122334455667788,  2'b00, 64'h0,                 0));
    tab64.push_back(mk(0, 3'b010, 32'h10C, 64'h0,                 64'h8000000100000000,  32'h108, 8'hF0, 64'h0,                 2'b00, 64'hFFFFFFFF80000001,  1));
    tab64.push_back(mk(0, 3'b110, 32'h10C, 64'h0,                 64'h8000000100000000,  32'h108, 8'hF0, 64'h0,                 2'b00, 64'h0000000080000001,  0));
    tab64.push_back(mk(0, 3'b000, 32'h10F, 64'h0,                 64'hFE00000000000000,  32'h108, 8'h80, 64'h0,                 2'b00, 64'hFFFFFFFFFFFFFFFE,  2));
    tab64.push_back(mk(0, 3'b011, 32'h104, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b01, 64'h0,                 0));
    tab64.push_back(mk(0, 3'b111, 32'h100, 64'h0,                 64'h0,                 32'h0,   8'h00, 64'h0,                 2'b10, 64'h0,                 0));

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", a_req_ready, 1'b1);
    check("rst_stall", a_stall, 1'b0);
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst_rsp_err", a_rsp_err, 2'b00);
    check("rst_mem_req", a_mem_req, 1'b0);
    check("rst_mem_bus", {a_mem_we, a_mem_addr, a_mem_mask, a_mem_wdata}, '0);
    check("rst_req_ready64", b_req_ready, 1'b1);
    rst = 1'b1;

    foreach (tab32[i]) xact($sformatf("v32_%0d", i), tab32[i]);

    // Timeout with TIMEOUT=4, then a late mem_valid that must be ignored.
    @(negedge clk);
    check("to_req_ready", a_req_ready, 1'b1);
    v = mk(0, 3'b010, 32'h100, 64'h0, 64'h0, 32'h100, 8'h0F, 64'h0, 2'b11, 64'h0, 0);
    drive_req(v);
    e.err = 2'b11; e.rdata = 64'h0;
    sb.push_back(e);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle_req();
      check($sformatf("to_mem_req_c%0d", k), a_mem_req, 1'b1);
      check($sformatf("to_no_rsp_c%0d", k), a_rsp_valid, 1'b0);
    end
    @(negedge clk);
    check("to_mem_req_drop", a_mem_req, 1'b0);
    check_rsp("to");
    a_mem_valid = 1'b1; a_mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("to_rsp_pulse", a_rsp_valid, 1'b0);
    check("to_req_ready_after", a_req_ready, 1'b1);
    check("to_late_valid_mem_req", a_mem_req, 1'b0);
    @(negedge clk);
    a_mem_valid = 1'b0; a_mem_rdata = '1;
    check("to_stray_no_rsp", a_rsp_valid, 1'b0);
    check("to_stray_stall", a_stall, 1'b0);

    // Reset while BUSY: mem_req and stall drop asynchronously, no response.
    @(negedge clk);
    v = mk(1, 3'b010, 32'h300, 64'h0BAD_F00D, 64'h0, 32'h300, 8'h0F, 64'h0BAD_F00D, 2'b00, 64'h0, 0);
    drive_req(v);
    @(negedge clk);
    idle_req();
    check("rb_mem_req_busy", a_mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rb_mem_req_async", a_mem_req, 1'b0);
    check("rb_stall_async", a_stall, 1'b0);
    repeat (2) @(negedge clk);
    check("rb_no_rsp_in_reset", a_rsp_valid, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rb_no_rsp_after_%0d", k), a_rsp_valid, 1'b0);
      check($sformatf("rb_req_ready_%0d", k), a_req_ready, 1'b1);
    end
    xact("rb_sw", v);

    use64 = 1'b1;
    foreach (tab64[i]) xact($sformatf("v64_%0d", i), tab64[i]);

    @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'h0);
    check("final_idle32", a_req_ready, 1'b1);
    check("final_idle64", b_req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Parametrised load/store unit that sits between the core's execute stage and the data memory port. It decodes load and store size and sign from `funct3`, and generates the aligned word address, byte mask and lane-shifted store data. It runs a request/valid handshake with a memory that may take multiple cycles, and returns extended load data. It also detects misaligned or illegal accesses and memory timeouts, and holds `stall` high while a transaction is in flight.

## Interface
- `DATA_W`, 32: memory/data width, 32 or 64; 64 enables LD/SD/LWU.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 15: maximum number of `mem_req` cycles waited for `mem_valid`; 0 disables the timeout.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents an access.
- `req_ready`  out  1  unit idle, access accepted when both high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV size/sign code.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-aligned.
- `stall`  out  1  high in BUSY and RESP.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.
- `rsp_err`  out  2  00 ok, 01 misaligned, 10 illegal size, 11 timeout.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_W  address with low log2(DATA_W/8) bits zeroed.
- `mem_mask`  out  DATA_W/8  byte-lane enables.
- `mem_wdata`  out  DATA_W  lane-shifted store data.
- `mem_valid`  in  1  memory completes the current request.
- `mem_rdata`  in  DATA_W  full-width read data.

## Operation
- **FSM states:** IDLE, BUSY, RESP. Reset state is IDLE.
- **IDLE:** `req_ready`=1. On accept, decode size (B/H/W/D) and `off` = `req_addr`[log2(DATA_W/8)-1:0].
  - Illegal `funct3` (111 always; 011 and 110 when DATA_W=32) goes to RESP with error 10.
  - Misaligned access (H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0) goes to RESP with error 01.
  - Otherwise latch all request fields and go to BUSY. Illegal-size takes priority over misaligned.
- **BUSY:** `mem_req`=1 and `mem_*` outputs held constant.
  - `mem_mask` = ((1<<bytes)-1)<<off.
  - `mem_wdata` = `req_wdata`<<(8·off).
  - `mem_valid` sampled high: capture `mem_rdata` and go to RESP with error 00.
  - Timeout: after TIMEOUT BUSY cycles with no `mem_valid`, go to RESP with error 11.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE.
- **Load result:** the selected lanes are shifted down by 8·off. LB/LH/LW (and LD) sign-extend; LBU/LHU/LWU zero-extend to DATA_W.
- **Outside BUSY:** `mem_req`, `mem_we`, `mem_addr`, `mem_mask` and `mem_wdata` are all 0.
- **Stray `mem_valid`:** ignored in IDLE and RESP.
- **Timeout counter:** width clog2(TIMEOUT+1), cleared on entry to BUSY. `mem_valid` arriving in the final counted cycle counts as success.

## Timing
- All outputs are registered, except `req_ready` and `stall`, which decode from state.
- **Reset values:** state IDLE; `req_ready`=1; `stall`, `rsp_valid` and `mem_req` = 0; `rsp_rdata`, `rsp_err` and all `mem_*` = 0.
- **Reset mid-transaction:** reset asserted in BUSY drops `mem_req` immediately (asynchronous), and no response is ever issued.
- **Normal latency:** accept in cycle N; `mem_req` high from N+1. With `mem_valid` high in cycle M ≥ N+1, `rsp_valid` is high in M+1. Minimum 2 cycles.
- **Error latency:** `rsp_valid` in N+1; `mem_req` never asserted.
- **Timeout:** `mem_req` high in N+1..N+TIMEOUT, dropped in N+TIMEOUT+1, and `rsp_valid` with error 11 in N+TIMEOUT+1.
- **Back-to-back:** the next request can be accepted in the cycle after RESP.
- `req_*` inputs are ignored while `req_ready`=0.

## Test plan
- **SW, DATA_W=32:** addr 0x104, data 0xDEADBEEF, `mem_valid` in N+1 -> `mem_addr` 0x104, `mem_mask` 0xF, `mem_wdata` 0xDEADBEEF, `mem_we`=1; `rsp_valid` in N+2 with error 00 and `rsp_rdata` 0.
- **LB / LBU:** addr 0x203, `mem_rdata` 0x80123456 -> `mem_addr` 0x200, `mem_mask` 0x8; LB gives `rsp_rdata` 0xFFFFFF80, LBU gives 0x00000080.
- **SH then misaligned LH:** SH at addr 0x102, data 0x0000ABCD -> `mem_mask` 0xC, `mem_wdata` 0xABCD0000. LH at 0x101 -> error 01 in N+1, `mem_req` stays 0.
- **Timeout:** TIMEOUT=4, `mem_valid` held 0 -> `mem_req` high exactly 4 cycles, then `rsp_valid` with error 11. A late `mem_valid` is ignored, and `req_ready`=1 the cycle after.
- **Reset mid-BUSY:** `rst` low while BUSY -> `mem_req`=0 and `stall`=0 immediately, no `rsp_valid` ever. After release, `req_ready`=1 and the next SW completes normally.
- **DATA_W=64:** SD at 0x108 -> `mem_mask` 0xFF. LW at 0x10C with upper word 0x8000_0001 -> `mem_mask` 0xF0, `rsp_rdata` 0xFFFFFFFF80000001. With DATA_W=32, `funct3` 011 -> error 10.
